sclk_tick_rx: RTL
=================

Name: sclk_tick_rx

Overview:
- Receive-side partner of the CLK-domain slow-clock divider. Takes the divided square wave S_CLK back into the CLK domain and synchronises it.
- Emits single-cycle RISE/FALL enables, so downstream logic never clocks on S_CLK directly.
- Measures every half-period and runs a lock/loss monitor that flags a stalled or off-frequency slow clock.

Parameters:
- SYNC_STAGES, 2: flip-flops in the S_CLK synchroniser, minimum 2.
- HALF_PERIOD, 20000: expected CLK cycles between consecutive S_CLK edges.
- TOL, 16: allowed deviation of a measured half-period, ± CLK cycles.
- CNT_W, 26: width of the interval counter and of MEAS.
- LOCK_COUNT, 4: consecutive in-tolerance intervals needed to declare lock.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- S_CLK  in  1  divided slow clock, asynchronous to CLK in general.
- ERR_CLR  in  1  one-cycle pulse; clears sticky ERR.
- RISE  out  1  one-cycle pulse per synchronised S_CLK rising edge.
- FALL  out  1  one-cycle pulse per synchronised S_CLK falling edge.
- MEAS  out  CNT_W  last measured edge-to-edge interval in CLK cycles.
- LOCKED  out  1  high while in state LOCK.
- ERR  out  1  sticky; set on loss of lock.
- STATE  out  2  current FSM state, for debug.

Behaviour:
- Reset: one clock, synchronous, active-high; CLK and RST as named above.
  - While RST is high at a CLK edge, all registers clear: synchroniser to 0, RISE=0, FALL=0, MEAS=0, LOCKED=0, ERR=0, STATE=IDLE.
  - Interval counter CNT=0, good-interval count GOOD=0.
  - Reset mid-operation discards all history; no edge is reported on the first cycle after reset even if S_CLK=1.
- Edge detect:
  - SYNC_STAGES-deep synchroniser, then a one-cycle delayed copy.
  - RISE = sync & ~prev; FALL = ~sync & prev.
  - Latency from S_CLK transition to pulse: SYNC_STAGES+1 CLK edges.
  - EDGE = RISE | FALL.
- Interval counter:
  - CNT increments every cycle and saturates at all-ones, never wrapping.
  - On an EDGE cycle: MEAS <= CNT+1, saturating, and CNT <= 0.
  - A steady divider toggling every H cycles therefore yields MEAS = H.
- Good interval: HALF_PERIOD-TOL <= CNT+1 <= HALF_PERIOD+TOL, evaluated on the EDGE cycle.
- Timeout: CNT+1 > HALF_PERIOD+TOL with no edge in that cycle.
- FSM, encoded IDLE=0, ACQ=1, LOCK=2, LOST=3:
  - IDLE: first EDGE -> ACQ with GOOD=0. That first interval is not judged, but MEAS still updates.
  - ACQ:
    - Good EDGE -> GOOD+1.
    - When GOOD reaches LOCK_COUNT -> LOCK, and LOCKED rises the following cycle.
    - Bad EDGE -> GOOD=0, stay in ACQ.
    - Timeout -> IDLE.
  - LOCK:
    - Good EDGE -> stay.
    - Bad EDGE or timeout -> LOST, ERR <= 1.
  - LOST: next EDGE -> ACQ with GOOD=0. That interval is not judged.
- ERR:
  - Set only on the LOCK->LOST transition.
  - Cleared by ERR_CLR or RST.
  - If set and clear occur in the same cycle, set wins.
- RISE and FALL are emitted in every state; LOCKED is a qualifier only.
- A single EDGE cycle that also satisfies the timeout condition counts as a bad edge, not as a timeout.

Optional Feature:
- Macro: SCLK_GLITCH_FILTER_EN.
- When defined:
  - After the synchroniser, the filtered level changes only after the synchronised value has differed from it for 3 consecutive cycles.
  - Edge latency becomes SYNC_STAGES+3 cycles.
  - Pulses shorter than 3 CLK cycles produce no RISE/FALL.
- When undefined: the filter is absent and latency is SYNC_STAGES+1.

Decomposition:
- Shared package sclk_pkg holds:
  - FSM state localparams (IDLE, ACQ, LOCK, LOST) and the 2-bit state type.
  - The defaults HALF_PERIOD=20000 and CNT_W=26, so the divider and receiver share one value.
- One natural sub-module: sclk_sync_edge. It contains the synchroniser, the optional glitch filter and the delayed copy, and outputs RISE/FALL.
- The counter and FSM stay in sclk_tick_rx.

Test Plan:
- Run with HALF_PERIOD=20, TOL=2, LOCK_COUNT=4, SYNC_STAGES=2.
- Drive S_CLK toggling every 20 CLK:
  - First RISE appears 3 CLK after the S_CLK edge.
  - MEAS=20 from the second edge on.
  - LOCKED=1 after the 5th edge; ERR stays 0.
- After lock, hold S_CLK static:
  - At CNT+1=23 the FSM moves to LOST, ERR=1, LOCKED=0.
  - The next edge moves to ACQ; re-lock occurs after 4 more good edges.
- Toggle every 17 CLK:
  - MEAS=17 every edge, state stays ACQ, LOCKED never asserts.
  - Switching to 21 gives lock after 4 edges.
- In LOCK, assert RST for one cycle mid-period:
  - Next cycle STATE=IDLE, MEAS=0, ERR=0.
  - No RISE/FALL is issued although S_CLK=1.
- With ERR=1, assert ERR_CLR in the same cycle as a new LOCK->LOST event: ERR stays 1. ERR_CLR alone clears it.
- With SCLK_GLITCH_FILTER_EN defined:
  - A 2-cycle high pulse on S_CLK gives no RISE.
  - A 3-cycle high pulse gives a RISE 5 CLK after the pulse starts.

Source files
------------

// File: rtl/sclk_pkg.sv
// -----------------------------------------------------------------------------
// sclk_pkg
// Shared definitions for the slow-clock divider and its receive-side partner
// sclk_tick_rx. Holds the FSM state type and the default half-period / counter
// width, so the transmitter and the receiver are built from one value.
// -----------------------------------------------------------------------------
package sclk_pkg;

    // CLK cycles between consecutive S_CLK edges, and the interval counter width
    // (26 bits comfortably covers a saturating count well beyond 20000).
    localparam int HALF_PERIOD_DEF = 20000;
    localparam int CNT_W_DEF       = 26;

    // Lock-monitor states. The encoding is visible on the STATE debug port and
    // must stay fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } state_t;

endpackage

// File: rtl/sclk_sync_edge.sv
// -----------------------------------------------------------------------------
// sclk_sync_edge
// Brings the asynchronous slow clock S_CLK into the CLK domain and turns its
// transitions into single-cycle, registered RISE/FALL enables.
//
// Build option: define SCLK_GLITCH_FILTER_EN to insert a 3-sample glitch filter
// between the synchroniser and the edge detector (edge latency SYNC_STAGES+3
// instead of SYNC_STAGES+1; pulses shorter than 3 CLK cycles are dropped).
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   s_clk  in   slow clock, asynchronous to clk
//   rise   out  one-cycle pulse per synchronised rising edge
//   fall   out  one-cycle pulse per synchronised falling edge
// -----------------------------------------------------------------------------
module sclk_sync_edge #(
    parameter int SYNC_STAGES = 2   // minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic s_clk,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level;    // level presented to the edge detector
    logic                   prev_q;   // level delayed by one cycle

    // Shift register synchroniser; stage 0 is the only flop that may go
    // metastable, later stages give it a full cycle to settle.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample pre-edge values and simulation matches the synthesised registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], s_clk};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SCLK_GLITCH_FILTER_EN
    // Two-deep history of the synchronised value. The level follows the
    // synchroniser only once the current and both previous samples agree,
    // i.e. after it has differed from the held level for 3 consecutive cycles.
    // The held level itself is prev_q, so no separate filter register is needed.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_out};
        end
    end

    // NOTE: the default assignment comes first so every path drives 'level';
    // a path left unassigned in always_comb would infer a latch.
    always_comb begin
        level = prev_q;
        if ((sync_out == hist_q[0]) && (sync_out == hist_q[1])) begin
            level = sync_out;
        end
    end
`else
    assign level = sync_out;
`endif

    // Registered detector: the extra flop costs one cycle of latency but gives
    // glitch-free single-cycle enables to downstream logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            prev_q <= level;
            rise   <= level & ~prev_q;
            fall   <= ~level & prev_q;
        end
    end

endmodule

// File: rtl/sclk_tick_rx.sv
// -----------------------------------------------------------------------------
// sclk_tick_rx
// Receive-side partner of the slow-clock divider. Synchronises S_CLK, emits
// single-cycle RISE/FALL enables, measures each edge-to-edge interval and runs
// a lock/loss monitor (IDLE -> ACQ -> LOCK, LOST on a bad interval or stall).
//
// Build option: SCLK_GLITCH_FILTER_EN enables the glitch filter inside
// sclk_sync_edge (see that file); the monitor logic is unaffected.
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   S_CLK    in   divided slow clock, asynchronous to CLK
//   ERR_CLR  in   one-cycle pulse, clears sticky ERR (a simultaneous set wins)
//   RISE     out  one-cycle pulse per synchronised S_CLK rising edge
//   FALL     out  one-cycle pulse per synchronised S_CLK falling edge
//   MEAS     out  last measured edge-to-edge interval in CLK cycles
//   LOCKED   out  high while the monitor is in LOCK
//   ERR      out  sticky, set on the LOCK -> LOST transition
//   STATE    out  current monitor state (IDLE=0, ACQ=1, LOCK=2, LOST=3)
// -----------------------------------------------------------------------------
module sclk_tick_rx
    import sclk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int TOL         = 16,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S_CLK,
    input  logic             ERR_CLR,
    output logic             RISE,
    output logic             FALL,
    output logic [CNT_W-1:0] MEAS,
    output logic             LOCKED,
    output logic             ERR,
    output logic [1:0]       STATE
);

    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(HALF_PERIOD + TOL);
    localparam int               GOOD_W = $clog2(LOCK_COUNT + 1);

    logic             edge_det;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] meas_q;
    logic             in_window;
    logic             timeout;
    state_t           state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic             err_q, err_d;

    sclk_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (CLK),
        .rst   (RST),
        .s_clk (S_CLK),
        .rise  (RISE),
        .fall  (FALL)
    );

    assign edge_det = RISE | FALL;

    // cnt_inc is the length of the interval if it ended this cycle; it is
    // both the next counter value and the value captured into MEAS.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    assign in_window = (cnt_inc >= WIN_LO) && (cnt_inc <= WIN_HI);
    // An edge arriving in the overdue cycle is judged as a bad edge, so the
    // timeout only fires when no edge is present.
    assign timeout   = !edge_det && (cnt_inc > WIN_HI);

    // Interval counter and measurement register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            meas_q <= '0;
        end else if (edge_det) begin
            cnt_q  <= '0;
            meas_q <= cnt_inc;
        end else begin
            cnt_q  <= cnt_inc;
        end
    end

    // Monitor state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            good_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    // Monitor next-state logic. The first interval after IDLE or LOST is not
    // judged: it starts at an arbitrary point, not at a real S_CLK edge.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;

        // Clear first, so a set further down in the same cycle takes priority.
        if (ERR_CLR) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (edge_det) begin
                    if (in_window) begin
                        good_d = good_q + 1'b1;
                        if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            end
            LOCK: begin
                if ((edge_det && !in_window) || timeout) begin
                    state_d = LOST;
                    err_d   = 1'b1;
                end
            end
            LOST: begin
                if (edge_det) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    assign MEAS   = meas_q;
    assign LOCKED = (state_q == LOCK);
    assign ERR    = err_q;
    assign STATE  = state_q;

endmodule
